// File: rtl/imem_loader.sv
// Byte-serial writer for the instruction memory: takes 32-bit words over valid/ready
// and writes each one as four little-endian bytes at consecutive addresses.
module imem_loader #(
    parameter int unsigned DEPTH     = 36,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_word,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              load_done,
    output logic              overflow,
    output logic [CNT_W-1:0]  words_loaded
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t            state_q;
    logic [1:0]        b_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [31:0]       word_q;
    logic              last_q;
    logic              in_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              load_done_q;
    logic              overflow_q;
    logic [CNT_W-1:0]  words_loaded_q;

    logic              transfer;
    logic              word_fits;
    logic [ADDR_W:0]   ptr_end;
    logic [1:0]        b_d;
    logic [ADDR_W-1:0] byte_addr_d;
    logic [7:0]        byte_data_d;
    logic [CNT_W-1:0]  words_loaded_d;

    assign transfer = in_valid && in_ready_q;

    // The fit check runs one bit wider than the pointer so a word straddling the
    // top of the address space is rejected instead of wrapping into a false pass.
    assign ptr_end   = {1'b0, ptr_q} + (ADDR_W+1)'(4);
    assign word_fits = (ptr_end <= (ADDR_W+1)'(DEPTH));

    // Outputs are registered, so while byte b is on the bus we prepare byte b+1.
    assign b_d         = b_q + 2'd1;
    assign byte_addr_d = ptr_q + ADDR_W'(b_d);
    assign byte_data_d = word_q[8*b_d +: 8];

    assign words_loaded_d = (&words_loaded_q) ? words_loaded_q : words_loaded_q + CNT_W'(1);

    // NOTE: all state lives in one clocked block using non-blocking assignments, so
    // every register sees the pre-edge values of the others regardless of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the latched word is reset along with the control state; it is a
            // handful of flops, not a memory array, so the reset costs nothing real.
            state_q        <= ST_IDLE;
            b_q            <= 2'd0;
            ptr_q          <= BASE;
            word_q         <= 32'd0;
            last_q         <= 1'b0;
            in_ready_q     <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= 8'd0;
            load_done_q    <= 1'b0;
            overflow_q     <= 1'b0;
            words_loaded_q <= '0;
        end else if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            state_q        <= ST_ACCEPT;
            ptr_q          <= BASE;
            words_loaded_q <= '0;
            overflow_q     <= 1'b0;
            load_done_q    <= 1'b0;
            in_ready_q     <= 1'b1;
            mem_we_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCEPT: begin
                    if (transfer) begin
                        word_q     <= in_word;
                        last_q     <= in_last;
                        in_ready_q <= 1'b0;
                        if (!word_fits) begin
                            overflow_q  <= 1'b1;
                            load_done_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            b_q         <= 2'd0;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= ptr_q;
                            mem_wdata_q <= in_word[7:0];
                            state_q     <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (b_q == 2'd3) begin
                        mem_we_q       <= 1'b0;
                        ptr_q          <= ptr_q + ADDR_W'(4);
                        words_loaded_q <= words_loaded_d;
                        if (last_q) begin
                            load_done_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= ST_ACCEPT;
                        end
                    end else begin
                        b_q         <= b_d;
                        mem_addr_q  <= byte_addr_d;
                        mem_wdata_q <= byte_data_d;
                    end
                end
                default: begin
                    // IDLE and DONE simply hold until a start pulse
                    in_ready_q <= 1'b0;
                    mem_we_q   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign load_done    = load_done_q;
    assign overflow     = overflow_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver predicts each byte write when a word
// is handed over, and an independent monitor checks every mem_we cycle against it.
module tb_imem_loader;

    localparam int unsigned DEPTH  = 36;
    localparam int unsigned BASE   = 0;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_word;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              load_done;
    logic              overflow;
    logic [CNT_W-1:0]  words_loaded;

    imem_loader #(
        .DEPTH    (DEPTH),
        .BASE_ADDR(BASE),
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_word     (in_word),
        .in_last     (in_last),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .load_done   (load_done),
        .overflow    (overflow),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  model_ptr;
    int  model_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every byte write must match the oldest predicted write.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            check("we_while_ready", {31'd0, in_ready}, 32'd0);
            check("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e.addr);
                check("wr_data", {24'd0, mem_wdata}, {24'd0, e.data});
            end
        end
    end

    // Offer one word; returns 1 time unit after the edge that accepted it.
    task automatic send_word(input logic [31:0] w, input logic l, input bit toggle);
        bit accepted = 1'b0;
        int waited   = 0;
        in_word = w;
        in_last = l;
        while (!accepted && waited < 40) begin
            @(negedge clk);
            in_valid = toggle ? ~in_valid : 1'b1;
            if (in_valid && in_ready) begin
                accepted = 1'b1;
                if (model_ptr + 4 <= int'(DEPTH)) begin
                    for (int i = 0; i < 4; i++) begin
                        wr_t e;
                        e.addr = 32'(model_ptr + i);
                        e.data = w[8*i +: 8];
                        exp_q.push_back(e);
                    end
                    model_ptr += 4;
                    if (model_cnt < 255) model_cnt++;
                end
            end
            waited++;
        end
        check("accept_in_time", {31'd0, accepted}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Called right after send_word: four write cycles, then the idle/done cycle.
    task automatic wait_write_done(input bit last);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("we_window", {31'd0, mem_we}, 32'd1);
            if (k == 3) check("done_not_early", {31'd0, load_done}, 32'd0);
        end
        @(negedge clk);
        check("we_dropped", {31'd0, mem_we}, 32'd0);
        if (last) check("load_done_rise", {31'd0, load_done}, 32'd1);
        else      check("ready_again", {31'd0, in_ready}, 32'd1);
        check("words_loaded", {24'd0, words_loaded}, 32'(model_cnt));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        model_ptr = int'(BASE);
        model_cnt = 0;
    endtask

    task automatic check_session_open();
        @(negedge clk);
        check("sess_load_done", {31'd0, load_done}, 32'd0);
        check("sess_overflow", {31'd0, overflow}, 32'd0);
        check("sess_words", {24'd0, words_loaded}, 32'd0);
        check("sess_ready", {31'd0, in_ready}, 32'd1);
    endtask

    logic [31:0] prog10 [10];

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_word = 32'd0; in_last = 1'b0;
        model_ptr = int'(BASE); model_cnt = 0;
        prog10 = '{32'h00221820, 32'h00642022, 32'h8C010004, 32'hAC020008, 32'h10220003,
                   32'h08000000, 32'h0000000C, 32'hFFFFFFFF, 32'h01234567, 32'h89ABCDEF};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_words", {24'd0, words_loaded}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_not_ready", {31'd0, in_ready}, 32'd0);

        // Two-word program
        pulse_start();
        check_session_open();
        send_word(32'h00221820, 1'b0, 1'b0);
        wait_write_done(1'b0);
        send_word(32'h00642022, 1'b1, 1'b0);
        wait_write_done(1'b1);
        check("t1_overflow", {31'd0, overflow}, 32'd0);
        check("t1_not_ready", {31'd0, in_ready}, 32'd0);

        // Ten words into 36 bytes: the tenth overflows
        pulse_start();
        check_session_open();
        for (int i = 0; i < 9; i++) begin
            send_word(prog10[i], 1'b0, 1'b0);
            wait_write_done(1'b0);
        end
        send_word(prog10[9], 1'b1, 1'b0);
        @(negedge clk);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_done", {31'd0, load_done}, 32'd1);
        check("ovf_no_we", {31'd0, mem_we}, 32'd0);
        check("ovf_words", {24'd0, words_loaded}, 32'd9);
        repeat (3) @(negedge clk);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Restart from DONE clears flags and writes from address 0 again
        pulse_start();
        check_session_open();
        send_word(32'hDEADBEEF, 1'b1, 1'b0);
        wait_write_done(1'b1);

        // in_valid toggling every cycle, three words
        pulse_start();
        check_session_open();
        send_word(32'h11111111, 1'b0, 1'b1);
        send_word(32'h22334455, 1'b0, 1'b1);
        send_word(32'h66778899, 1'b1, 1'b1);
        begin
            int guard = 0;
            while (!load_done && guard < 20) begin
                @(negedge clk);
                guard++;
            end
        end
        check("toggle_done", {31'd0, load_done}, 32'd1);
        check("toggle_words", {24'd0, words_loaded}, 32'd3);

        // start during WRITE is ignored; in_word/in_last changes after accept do not matter
        pulse_start();
        check_session_open();
        send_word(32'hCAFEF00D, 1'b0, 1'b0);
        in_word = 32'hFFFFFFFF;
        in_last = 1'b1;
        fork
            wait_write_done(1'b0);
            begin
                @(negedge clk);
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join
        send_word(32'h0BADC0DE, 1'b1, 1'b0);
        wait_write_done(1'b1);
        check("ign_start_words", {24'd0, words_loaded}, 32'd2);

        // Reset while byte 2 of the second word is on the bus
        pulse_start();
        check_session_open();
        send_word(32'h11223344, 1'b0, 1'b0);
        wait_write_done(1'b0);
        send_word(32'hAABBCCDD, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("pre_rst_addr", mem_addr, 32'd6);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_we", {31'd0, mem_we}, 32'd0);
        check("rst_mid_addr", mem_addr, 32'd0);
        check("rst_mid_ready", {31'd0, in_ready}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_idle", {31'd0, in_ready}, 32'd0);
        end
        check("post_rst_done", {31'd0, load_done}, 32'd0);
        check("post_rst_words", {24'd0, words_loaded}, 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
